// File: rtl/systolic_pkg.sv
// Shared types, sizing constants and the saturating/wrapping accumulate helper
// for the output-stationary systolic array.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int unsigned ROWS_DEF  = 4;
    localparam int unsigned COLS_DEF  = 4;
    localparam int unsigned K_MAX_DEF = 256;
    localparam int unsigned FLUSH_CYC = ROWS_DEF + COLS_DEF - 1;
    localparam int unsigned KW        = $clog2(K_MAX_DEF + 1);

    // Wide container so one helper serves every accumulator width up to 62 bits.
    localparam int unsigned SUM_W = 64;

    // Returns {out_of_range, result}; result is clamped (sat) or wrapped to acc_w bits.
    function automatic logic [SUM_W:0] sat_add(
        input logic signed [SUM_W-1:0] acc,
        input logic signed [SUM_W-1:0] prod,
        input int unsigned             acc_w,
        input bit                      sat
    );
        logic signed [SUM_W-1:0] sum;
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        logic signed [SUM_W-1:0] res;
        logic                    ov;
        sum = acc + prod;
        hi  = $signed((SUM_W'(1) << (acc_w - 1)) - SUM_W'(1));
        lo  = ~hi;
        ov  = (sum > hi) || (sum < lo);
        if (!ov) begin
            res = sum;
        end else if (sat) begin
            res = (sum < lo) ? lo : hi;
        end else begin
            res = (sum <<< (SUM_W - acc_w)) >>> (SUM_W - acc_w);
        end
        return {ov, res};
    endfunction

endpackage

// File: rtl/systolic_array_os_pe.sv
// Processing element: forwards a east, w south and the valid tag, and keeps one
// output-stationary accumulator with a sticky overflow flag.
module sys_pe
    import systolic_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned SAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic signed [W-1:0]     a_i,
    input  logic signed [W-1:0]     w_i,
    input  logic                    v_i,
    output logic signed [W-1:0]     a_o,
    output logic signed [W-1:0]     w_o,
    output logic                    v_o,
    output logic signed [ACC_W-1:0] acc_o,
    output logic                    ovf_o
);

    localparam int unsigned PW = 2 * W;

    logic signed [W-1:0]     a_q;
    logic signed [W-1:0]     w_q;
    logic                    v_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic                    ovf_q;
    logic                    ovf_d;
    logic signed [PW-1:0]    prod_c;
    logic [SUM_W:0]          sum_c;

    assign prod_c = PW'(a_i) * PW'(w_i);
    assign sum_c  = sat_add(SUM_W'(acc_q), SUM_W'(prod_c), ACC_W, SAT != 0);

    // Clear wins over a same-cycle accumulate so a finished job leaves nothing behind.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (v_i) begin
            acc_d = ACC_W'(sum_c[SUM_W-1:0]);
            ovf_d = ovf_q | sum_c[SUM_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            w_q   <= '0;
            v_q   <= 1'b0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            a_q   <= a_i;
            w_q   <= w_i;
            v_q   <= v_i;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign a_o   = a_q;
    assign w_o   = w_q;
    assign v_o   = v_q;
    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/systolic_array_os.sv
// ROWS x COLS output-stationary systolic matrix multiplier: internal operand skew,
// PE grid, and a job FSM that sequences load, flush and row-by-row drain.
module systolic_array_os
    import systolic_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned ROWS  = ROWS_DEF,
    parameter int unsigned COLS  = COLS_DEF,
    parameter int unsigned K_MAX = K_MAX_DEF,
    parameter int unsigned SAT   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(K_MAX+1)-1:0]   k_len,
    output logic                         busy,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ROWS*W-1:0]            a_in,
    input  logic [COLS*W-1:0]            w_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [COLS*ACC_W-1:0]        out_data,
    output logic [$clog2(ROWS)-1:0]      out_row,
    output logic                         ovf,
    output logic                         done
);

    localparam int unsigned KLW     = $clog2(K_MAX + 1);
    localparam int unsigned RW      = $clog2(ROWS);
    localparam int unsigned FLUSH_N = ROWS + COLS - 1;
    localparam int unsigned FW      = $clog2(FLUSH_N + 1);

    state_e                  state_q, state_d;
    logic [KLW-1:0]          k_q, k_d;
    logic [KLW-1:0]          beat_q, beat_d;
    logic [FW-1:0]           flush_q, flush_d;
    logic [RW-1:0]           out_row_q, out_row_d;
    logic [COLS*ACC_W-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    ovf_q, ovf_d;
    logic                    done_q, done_d;
    logic                    busy_q, in_ready_q;
    logic                    clr_c;
    logic                    v_c;
    logic [RW-1:0]           load_row_c;
    logic [COLS*ACC_W-1:0]   sel_row_c;

    logic signed [W-1:0]     a_h   [ROWS][COLS];
    logic                    v_h   [ROWS][COLS];
    logic signed [W-1:0]     w_v   [ROWS][COLS];
    logic signed [W-1:0]     a_fw  [ROWS][COLS];
    logic signed [W-1:0]     w_fw  [ROWS][COLS];
    logic                    v_fw  [ROWS][COLS];
    logic signed [ACC_W-1:0] acc   [ROWS][COLS];
    logic [ROWS*COLS-1:0]    pe_ovf;
    logic [ROWS-1:0]         unused_east;
    logic [COLS-1:0]         unused_south;

    assign v_c = in_valid && in_ready_q;

    // Row lane r is delayed r cycles; data is zeroed on bubbles.
    for (genvar r = 0; r < ROWS; r++) begin : g_rskew
        logic [W-1:0] a_tok;
        assign a_tok = v_c ? a_in[r*W +: W] : '0;
        if (r == 0) begin : g_direct
            assign a_h[r][0] = a_tok;
            assign v_h[r][0] = v_c;
        end else begin : g_pipe
            localparam int unsigned DW = r * W;
            localparam int unsigned DV = r;
            logic [DW-1:0] a_sk_q;
            logic [DV-1:0] v_sk_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_sk_q <= '0;
                    v_sk_q <= '0;
                end else begin
                    a_sk_q <= (a_sk_q << W) | DW'(a_tok);
                    v_sk_q <= (v_sk_q << 1) | DV'(v_c);
                end
            end
            assign a_h[r][0] = a_sk_q[DW-1 -: W];
            assign v_h[r][0] = v_sk_q[DV-1];
        end
    end

    // Column lane c is delayed c cycles so every (a, w) pair meets in step.
    for (genvar c = 0; c < COLS; c++) begin : g_cskew
        logic [W-1:0] w_tok;
        assign w_tok = v_c ? w_in[c*W +: W] : '0;
        if (c == 0) begin : g_direct
            assign w_v[0][c] = w_tok;
        end else begin : g_pipe
            localparam int unsigned DW = c * W;
            logic [DW-1:0] w_sk_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    w_sk_q <= '0;
                end else begin
                    w_sk_q <= (w_sk_q << W) | DW'(w_tok);
                end
            end
            assign w_v[0][c] = w_sk_q[DW-1 -: W];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (c > 0) begin : g_west
                assign a_h[r][c] = a_fw[r][c-1];
                assign v_h[r][c] = v_fw[r][c-1];
            end
            if (r > 0) begin : g_north
                assign w_v[r][c] = w_fw[r-1][c];
            end
            if (c == COLS - 1) begin : g_east_edge
                assign unused_east[r] = ^{a_fw[r][c], v_fw[r][c]};
            end
            if (r == ROWS - 1) begin : g_south_edge
                assign unused_south[c] = ^w_fw[r][c];
            end
            sys_pe #(.W(W), .ACC_W(ACC_W), .SAT(SAT)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr_i (clr_c),
                .a_i   (a_h[r][c]),
                .w_i   (w_v[r][c]),
                .v_i   (v_h[r][c]),
                .a_o   (a_fw[r][c]),
                .w_o   (w_fw[r][c]),
                .v_o   (v_fw[r][c]),
                .acc_o (acc[r][c]),
                .ovf_o (pe_ovf[r*COLS+c])
            );
        end
    end

    // Row to present on the next drain load: 0 when entering DRAIN, else the following row.
    assign load_row_c = (state_q == DRAIN) ? out_row_q + RW'(1) : '0;

    always_comb begin
        sel_row_c = '0;
        for (int c = 0; c < COLS; c++) begin
            sel_row_c[c*ACC_W +: ACC_W] = acc[load_row_c][c];
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        beat_d      = beat_q;
        flush_d     = flush_q;
        out_row_d   = out_row_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q | (|pe_ovf);
        done_d      = 1'b0;
        clr_c       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k_d    = k_len;
                    beat_d = '0;
                    ovf_d  = 1'b0;
                    if (k_len == '0) begin
                        state_d     = DRAIN;
                        out_valid_d = 1'b1;
                        out_row_d   = '0;
                        out_data_d  = sel_row_c;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (v_c) begin
                    beat_d = beat_q + KLW'(1);
                    if (beat_d == k_q) begin
                        state_d = FLUSH;
                        flush_d = '0;
                    end
                end
            end
            FLUSH: begin
                if (flush_q == FW'(FLUSH_N - 1)) begin
                    state_d     = DRAIN;
                    out_valid_d = 1'b1;
                    out_row_d   = '0;
                    out_data_d  = sel_row_c;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (out_row_q == RW'(ROWS - 1)) begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        clr_c       = 1'b1;
                        out_valid_d = 1'b0;
                        out_row_d   = '0;
                        out_data_d  = '0;
                    end else begin
                        out_row_d  = load_row_c;
                        out_data_d = sel_row_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            beat_q      <= '0;
            flush_q     <= '0;
            out_row_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            beat_q      <= beat_d;
            flush_q     <= flush_d;
            out_row_q   <= out_row_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            busy_q      <= (state_d != IDLE);
            in_ready_q  <= (state_d == LOAD);
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign ovf       = ovf_q;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_array_os.sv
// Directed bench for systolic_array_os: a job table with hand-computed results run
// through a saturating and a wrapping instance, plus stall, abort and start-poke sequences.
module tb_systolic_array_os;
    import systolic_pkg::*;

    typedef struct packed {
        logic [8:0]        k;
        logic              gaps;
        logic [15:0][7:0]  a;      // [beat*4 + lane]
        logic [15:0][7:0]  w;      // [beat*4 + lane]
        logic [15:0][15:0] exp_s;  // [row*4 + col], SAT=1
        logic [15:0][15:0] exp_w;  // [row*4 + col], SAT=0
        logic              ovf;
    } job_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic          in_valid;
    logic [31:0]   a_in;
    logic [31:0]   w_in;
    logic          out_ready;
    logic          busy0, in_ready0, out_valid0, ovf0, done0;
    logic          busy1, in_ready1, out_valid1, ovf1, done1;
    logic [63:0]   out_data0, out_data1;
    logic [1:0]    out_row0, out_row1;

    int   n_pass;
    int   n_total;
    job_t jobs [6];

    systolic_array_os #(.SAT(1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy0),
        .in_valid(in_valid), .in_ready(in_ready0), .a_in(a_in), .w_in(w_in),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_row(out_row0), .ovf(ovf0), .done(done0)
    );

    systolic_array_os #(.SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy1),
        .in_valid(in_valid), .in_ready(in_ready1), .a_in(a_in), .w_in(w_in),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_row(out_row1), .ovf(ovf1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic job_t mk_job(input int k, input int av, input int wv,
                                    input int es, input int ew, input bit ov, input bit gaps);
        job_t j;
        j      = '0;
        j.k    = 9'(k);
        j.gaps = gaps;
        j.ovf  = ov;
        for (int i = 0; i < 16; i++) begin
            j.a[i]     = 8'(av);
            j.w[i]     = 8'(wv);
            j.exp_s[i] = 16'(es);
            j.exp_w[i] = 16'(ew);
        end
        return j;
    endfunction

    task automatic run_job(input job_t j, input int stall_row, input bit poke_start);
        int          b;
        int          guard;
        int          ph;
        int          fl;
        logic [63:0] er_s;
        logic [63:0] er_w;
        k_len = KW'(j.k);
        start = 1'b1;
        step();
        start = 1'b0;
        k_len = '0;
        b = 0; guard = 0; ph = 0;
        while (b < int'(j.k) && guard < 64) begin
            if (j.gaps && ph[0]) begin
                in_valid = 1'b0;
                a_in     = 32'h5555_5555;
                w_in     = 32'hAAAA_AAAA;
            end else begin
                in_valid = 1'b1;
                for (int l = 0; l < 4; l++) begin
                    a_in[l*8 +: 8] = j.a[b*4+l];
                    w_in[l*8 +: 8] = j.w[b*4+l];
                end
                chk("in_ready", 64'(in_ready0), 64'd1);
            end
            if (poke_start && b == 1) begin
                start = 1'b1;
                k_len = KW'(2);
            end
            if (in_valid && in_ready0) begin
                step();
                b++;
            end else begin
                step();
            end
            start = 1'b0;
            ph++;
            guard++;
        end
        in_valid = 1'b0;
        a_in     = '0;
        w_in     = '0;
        chk("load_beats", 64'(b), 64'(j.k));
        fl = 0;
        while (!out_valid0 && fl < 50) begin
            step();
            fl++;
        end
        chk("flush_cycles", 64'(fl), (j.k == 0) ? 64'd0 : 64'(FLUSH_CYC));
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                er_s[c*16 +: 16] = j.exp_s[r*4+c];
                er_w[c*16 +: 16] = j.exp_w[r*4+c];
            end
            chk("drain_valid", 64'(out_valid0), 64'd1);
            chk("drain_row", 64'(out_row0), 64'(r));
            chk("drain_data_sat", out_data0, er_s);
            chk("drain_data_wrap", out_data1, er_w);
            if (r == stall_row) begin
                out_ready = 1'b0;
                repeat (5) begin
                    step();
                    chk("stall_valid", 64'(out_valid0), 64'd1);
                    chk("stall_row", 64'(out_row0), 64'(r));
                    chk("stall_data", out_data0, er_s);
                    chk("stall_done", 64'(done0), 64'd0);
                end
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            if (r < 3) chk("early_done", 64'(done0), 64'd0);
        end
        chk("done_pulse", 64'(done0), 64'd1);
        chk("done_pulse_wrap", 64'(done1), 64'd1);
        chk("valid_after_done", 64'(out_valid0), 64'd0);
        chk("ovf_sat", 64'(ovf0), 64'(j.ovf));
        chk("ovf_wrap", 64'(ovf1), 64'(j.ovf));
        step();
        chk("done_one_cycle", 64'(done0), 64'd0);
        chk("idle_busy", 64'(busy0), 64'd0);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        in_valid  = 1'b0;
        a_in      = '0;
        w_in      = '0;
        out_ready = 1'b0;

        // Identity x B returns B; B[k][c] = 4k+c+1.
        jobs[0]   = '0;
        jobs[0].k = 9'd4;
        for (int b = 0; b < 4; b++) begin
            for (int l = 0; l < 4; l++) begin
                jobs[0].a[b*4+l]     = (b == l) ? 8'd1 : 8'd0;
                jobs[0].w[b*4+l]     = 8'(b*4 + l + 1);
                jobs[0].exp_s[b*4+l] = 16'(b*4 + l + 1);
                jobs[0].exp_w[b*4+l] = 16'(b*4 + l + 1);
            end
        end
        jobs[1] = mk_job(3,   -2,   5,    -30,   -30, 1'b0, 1'b1);
        jobs[2] = mk_job(4,  127, 127,  32767, -1020, 1'b1, 1'b0);
        jobs[3] = mk_job(3, -128, 127, -32768, 16768, 1'b1, 1'b0);
        jobs[4] = mk_job(1,    2,   3,      6,     6, 1'b0, 1'b0);
        jobs[5] = mk_job(0,    9,   9,      0,     0, 1'b0, 1'b0);

        repeat (3) step();
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_in_ready", 64'(in_ready0), 64'd0);
        chk("rst_out_valid", 64'(out_valid0), 64'd0);
        chk("rst_out_data", out_data0, 64'd0);
        chk("rst_out_row", 64'(out_row0), 64'd0);
        chk("rst_ovf", 64'(ovf0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        rst = 1'b0;
        step();
        chk("post_rst_busy", 64'(busy0), 64'd0);

        run_job(jobs[0], -1, 1'b0);
        run_job(jobs[1], -1, 1'b0);
        run_job(jobs[2],  1, 1'b0);
        run_job(jobs[3], -1, 1'b1);

        // Abort a saturating job partway through FLUSH.
        k_len = KW'(4);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1;
            a_in     = {4{8'd127}};
            w_in     = {4{8'd127}};
            chk("abort_in_ready", 64'(in_ready0), 64'd1);
            step();
        end
        in_valid = 1'b0;
        a_in     = '0;
        w_in     = '0;
        repeat (3) step();
        chk("abort_busy_pre", 64'(busy0), 64'd1);
        chk("abort_ovf_pre", 64'(ovf0), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 64'(busy0), 64'd0);
        chk("abort_in_ready0", 64'(in_ready0), 64'd0);
        chk("abort_out_valid", 64'(out_valid0), 64'd0);
        chk("abort_out_data", out_data0, 64'd0);
        chk("abort_out_row", 64'(out_row0), 64'd0);
        chk("abort_ovf", 64'(ovf0), 64'd0);
        chk("abort_done", 64'(done0), 64'd0);
        chk("abort_wrap_quiet", 64'({busy1, in_ready1, out_valid1, out_row1, ovf1}), 64'd0);

        run_job(jobs[4], -1, 1'b0);
        run_job(jobs[5], -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
